// File: rtl/imem_loadable_if.sv
// Fetch and image-load bus between the CPU front end / loader and imem_loadable.
interface imem_loadable_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = IDX_W + 1;

    // fetch port
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_rdy;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_err;

    // image load port
    logic              load_start;
    logic [IDX_W-1:0]  load_base;
    logic [LEN_W-1:0]  load_len;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              load_ready;
    logic              load_busy;
    logic              load_done;

    // requester / loader side
    modport master (
        output fetch_req, fetch_addr,
        output load_start, load_base, load_len, load_data, load_valid,
        input  fetch_rdy, fetch_valid, fetch_instr, fetch_err,
        input  load_ready, load_busy, load_done
    );

    // memory side
    modport slave (
        input  fetch_req, fetch_addr,
        input  load_start, load_base, load_len, load_data, load_valid,
        output fetch_rdy, fetch_valid, fetch_instr, fetch_err,
        output load_ready, load_busy, load_done
    );
endinterface

// File: rtl/imem_loadable.sv
// Loadable instruction memory: self-clears after reset, accepts a streamed
// program image, and serves word fetches with one cycle of latency.
module imem_loadable #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic         clk,
    input  logic         rst,
    imem_loadable_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = IDX_W + 1;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  clr_ptr;
    logic [IDX_W-1:0]  ptr;
    logic [LEN_W-1:0]  cnt;
    logic              done_q;
    logic              fvalid_q;
    logic [DATA_W-1:0] finstr_q;
    logic              ferr_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              fetch_fire;
    logic              addr_bad;
    logic [IDX_W-1:0]  fetch_idx;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Port status decoded straight from the state register.
    assign bus.fetch_rdy   = (state == IDLE);
    assign bus.load_ready  = (state == LOAD);
    assign bus.load_busy   = (state != IDLE);
    assign bus.load_done   = done_q;
    assign bus.fetch_valid = fvalid_q;
    assign bus.fetch_instr = finstr_q;
    assign bus.fetch_err   = ferr_q;

    // Fetch acceptance and address legality.
    assign fetch_fire = bus.fetch_req && (state == IDLE);
    assign fetch_idx  = bus.fetch_addr[IDX_W+1:2];
    assign addr_bad   = (bus.fetch_addr[1:0] != 2'b00) ||
                        ((bus.fetch_addr >> 2) >= ADDR_W'(DEPTH));

    // Single write port: zeroes during CLEAR, image words during LOAD.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ptr;
        mem_wdata = bus.load_data;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr;
            mem_wdata = '0;
        end else if (state == LOAD) begin
            mem_we    = bus.load_valid;
        end
    end

    // Memory array write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM: clear sweep, idle, and image streaming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ptr     <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + IDX_W'(1);
                    if (clr_ptr == IDX_W'(DEPTH - 1)) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (bus.load_start) begin
                        ptr <= bus.load_base;
                        cnt <= bus.load_len;
                        if (bus.load_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (bus.load_valid) begin
                        ptr <= ptr + IDX_W'(1);
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Registered fetch result; holds last value when nothing is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fvalid_q <= 1'b0;
            finstr_q <= '0;
            ferr_q   <= 1'b0;
        end else begin
            fvalid_q <= fetch_fire;
            if (fetch_fire) begin
                ferr_q   <= addr_bad;
                finstr_q <= addr_bad ? '0 : mem[fetch_idx];
            end
        end
    end
endmodule

// File: tb/tb_imem_loadable.sv
// Randomised self-checking bench for imem_loadable against an array model.
module tb_imem_loadable;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned IDX_W = 8;
    localparam int unsigned LEN_W = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] model_mem [DEPTH];

    imem_loadable_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) bus ();

    imem_loadable #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drive point / sample point: 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spec rule for a fetch result, computed from the model array.
    function automatic void model_fetch(input logic [31:0] a, output logic e, output logic [31:0] w);
        if (a[1:0] != 2'b00 || (a >> 2) >= DEPTH) begin
            e = 1'b1;
            w = 32'h0;
        end else begin
            e = 1'b0;
            w = model_mem[a >> 2];
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endfunction

    // One accepted fetch from IDLE; returns the observed result.
    task automatic fetch_once(input logic [31:0] a, output logic v, output logic [31:0] w, output logic e);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        tick();
        v = bus.fetch_valid;
        w = bus.fetch_instr;
        e = bus.fetch_err;
        bus.fetch_req = 1'b0;
    endtask

    // Wait for the clear sweep after rst falls; returns cycles until load_busy drops.
    task automatic wait_clear(output int cycles);
        cycles = 0;
        while (bus.load_busy && cycles < DEPTH + 8) begin
            tick();
            cycles++;
        end
    endtask

    // Stream an image with optional valid gaps; updates the model on each accepted word.
    task automatic load_image(input int base, input int len, input logic [31:0] words[$], input int gap_pct,
                              output int ready_bad, output logic done1, output logic done2);
        ready_bad = 0;
        bus.load_start = 1'b1;
        bus.load_base  = IDX_W'(base);
        bus.load_len   = LEN_W'(len);
        tick();
        bus.load_start = 1'b0;
        for (int i = 0; i < len; i++) begin
            int g = 0;
            while (g < 3 && $urandom_range(99) < gap_pct) begin
                bus.load_valid = 1'b0;
                tick();
                if (!bus.load_busy) ready_bad++;
                g++;
            end
            bus.load_valid = 1'b1;
            bus.load_data  = words[i];
            if (!bus.load_ready) ready_bad++;
            tick();
            model_mem[(base + i) % DEPTH] = words[i];
        end
        bus.load_valid = 1'b0;
        done1 = bus.load_done;
        tick();
        done2 = bus.load_done;
    endtask

    task automatic test_reset();
        int cyc;
        logic v, e;
        logic [31:0] w;
        model_clear();
        #2 rst = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (bus.fetch_valid !== 1'b0) $display("FAIL rst_fetch_valid got=%b exp=0", bus.fetch_valid); else n_pass++;
        n_checks++; if (bus.fetch_instr !== 32'h0) $display("FAIL rst_fetch_instr got=%h exp=0", bus.fetch_instr); else n_pass++;
        n_checks++; if (bus.fetch_err !== 1'b0) $display("FAIL rst_fetch_err got=%b exp=0", bus.fetch_err); else n_pass++;
        n_checks++; if (bus.load_done !== 1'b0) $display("FAIL rst_load_done got=%b exp=0", bus.load_done); else n_pass++;
        n_checks++; if (bus.load_ready !== 1'b0) $display("FAIL rst_load_ready got=%b exp=0", bus.load_ready); else n_pass++;
        n_checks++; if (bus.fetch_rdy !== 1'b0) $display("FAIL rst_fetch_rdy got=%b exp=0", bus.fetch_rdy); else n_pass++;
        n_checks++; if (bus.load_busy !== 1'b1) $display("FAIL rst_load_busy got=%b exp=1", bus.load_busy); else n_pass++;
        rst = 1'b0;
        wait_clear(cyc);
        n_checks++; if (cyc !== DEPTH) $display("FAIL clear_cycles got=%0d exp=%0d", cyc, DEPTH); else n_pass++;
        n_checks++; if (bus.fetch_rdy !== 1'b1) $display("FAIL idle_fetch_rdy got=%b exp=1", bus.fetch_rdy); else n_pass++;
        fetch_once(32'h000, v, w, e);
        n_checks++; if ({v, e, w} !== {1'b1, 1'b0, 32'h0}) $display("FAIL clr_fetch_000 got v=%b e=%b w=%h exp v=1 e=0 w=0", v, e, w); else n_pass++;
        fetch_once(32'h3FC, v, w, e);
        n_checks++; if ({v, e, w} !== {1'b1, 1'b0, 32'h0}) $display("FAIL clr_fetch_3fc got v=%b e=%b w=%h exp v=1 e=0 w=0", v, e, w); else n_pass++;
    endtask

    task automatic test_load_basic();
        logic [31:0] words[$] = '{32'h24010008, 32'h34020002, 32'h00411820, 32'h00622822};
        int rb;
        logic d1, d2, v, e, me;
        logic [31:0] w, mw;
        load_image(1, 4, words, 0, rb, d1, d2);
        n_checks++; if (rb !== 0) $display("FAIL basic_ready got=%0d bad beats exp=0", rb); else n_pass++;
        n_checks++; if ({d1, d2} !== 2'b10) $display("FAIL basic_done got=%b%b exp=10", d1, d2); else n_pass++;
        fetch_once(32'h004, v, w, e);
        n_checks++; if ({v, e, w} !== {1'b1, 1'b0, 32'h24010008}) $display("FAIL basic_fetch_004 got v=%b e=%b w=%h exp 24010008", v, e, w); else n_pass++;
        fetch_once(32'h010, v, w, e);
        n_checks++; if ({v, e, w} !== {1'b1, 1'b0, 32'h00622822}) $display("FAIL basic_fetch_010 got v=%b e=%b w=%h exp 00622822", v, e, w); else n_pass++;
        for (int a = 0; a <= 20; a += 4) begin
            fetch_once(32'(a), v, w, e);
            model_fetch(32'(a), me, mw);
            n_checks++; if ({v, e, w} !== {1'b1, me, mw}) $display("FAIL basic_fetch addr=%h got e=%b w=%h exp e=%b w=%h", a, e, w, me, mw); else n_pass++;
        end
    endtask

    task automatic test_errors();
        logic [31:0] bad[$] = '{32'h006, 32'h400, 32'h001, 32'h3FF, 32'hFFFFFFFC, 32'h00010000};
        logic v, e;
        logic [31:0] w;
        foreach (bad[i]) begin
            fetch_once(bad[i], v, w, e);
            n_checks++; if ({v, e, w} !== {1'b1, 1'b1, 32'h0}) $display("FAIL err_fetch addr=%h got v=%b e=%b w=%h exp v=1 e=1 w=0", bad[i], v, e, w); else n_pass++;
        end
        tick();
        n_checks++; if ({bus.fetch_valid, bus.fetch_err, bus.fetch_instr} !== {1'b0, 1'b1, 32'h0}) $display("FAIL err_hold got v=%b e=%b w=%h exp v=0 e=1 w=0", bus.fetch_valid, bus.fetch_err, bus.fetch_instr); else n_pass++;
        fetch_once(32'h004, v, w, e);
        tick(); tick();
        n_checks++; if ({bus.fetch_valid, bus.fetch_err, bus.fetch_instr} !== {1'b0, 1'b0, 32'h24010008}) $display("FAIL ok_hold got v=%b e=%b w=%h exp v=0 e=0 w=24010008", bus.fetch_valid, bus.fetch_err, bus.fetch_instr); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] words[$];
        logic [31:0] addrs[$] = '{32'h3F8, 32'h3FC, 32'h000, 32'h004};
        int rb;
        logic d1, d2, v, e;
        logic [31:0] w;
        for (int i = 0; i < 4; i++) words.push_back($urandom());
        load_image(254, 4, words, 50, rb, d1, d2);
        n_checks++; if (rb !== 0) $display("FAIL wrap_ready got=%0d bad beats exp=0", rb); else n_pass++;
        n_checks++; if ({d1, d2} !== 2'b10) $display("FAIL wrap_done got=%b%b exp=10", d1, d2); else n_pass++;
        foreach (addrs[i]) begin
            fetch_once(addrs[i], v, w, e);
            n_checks++; if ({v, e, w} !== {1'b1, 1'b0, words[i]}) $display("FAIL wrap_fetch addr=%h got e=%b w=%h exp e=0 w=%h", addrs[i], e, w, words[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] addrs[$] = '{32'h028, 32'h02C, 32'h030, 32'h034, 32'h004, 32'h3FC};
        int cyc;
        logic v, e;
        logic [31:0] w;
        bus.load_start = 1'b1;
        bus.load_base  = IDX_W'(10);
        bus.load_len   = LEN_W'(4);
        tick();
        bus.load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = $urandom() | 32'h1;
            tick();
        end
        bus.load_valid = 1'b0;
        rst = 1'b1;
        tick(); tick();
        n_checks++; if ({bus.load_busy, bus.load_ready, bus.fetch_rdy} !== 3'b100) $display("FAIL midrst_status got busy/ready/rdy=%b%b%b exp=100", bus.load_busy, bus.load_ready, bus.fetch_rdy); else n_pass++;
        rst = 1'b0;
        model_clear();
        wait_clear(cyc);
        n_checks++; if (cyc !== DEPTH) $display("FAIL midrst_clear_cycles got=%0d exp=%0d", cyc, DEPTH); else n_pass++;
        foreach (addrs[i]) begin
            fetch_once(addrs[i], v, w, e);
            n_checks++; if ({v, e, w} !== {1'b1, 1'b0, 32'h0}) $display("FAIL midrst_fetch addr=%h got v=%b e=%b w=%h exp v=1 e=0 w=0", addrs[i], v, e, w); else n_pass++;
        end
    endtask

    task automatic test_fetch_during_load();
        logic [31:0] one[$];
        logic [31:0] w0;
        int rb, blocked;
        logic d1, d2, v, e;
        logic [31:0] w;
        w0 = $urandom() | 32'h1;
        one.push_back(w0);
        load_image(100, 1, one, 0, rb, d1, d2);
        fetch_once(32'h190, v, w, e);
        n_checks++; if ({v, e, w} !== {1'b1, 1'b0, w0}) $display("FAIL fdl_pre got e=%b w=%h exp e=0 w=%h", e, w, w0); else n_pass++;
        bus.load_start = 1'b1;
        bus.load_base  = IDX_W'(0);
        bus.load_len   = LEN_W'(3);
        tick();
        bus.load_start = 1'b0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h190;
        n_checks++; if (bus.fetch_rdy !== 1'b0) $display("FAIL fdl_rdy got=%b exp=0", bus.fetch_rdy); else n_pass++;
        blocked = 0;
        tick();
        if (bus.fetch_valid !== 1'b0) blocked++;
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = $urandom();
            model_mem[i]   = bus.load_data;
            tick();
            if (bus.fetch_valid !== 1'b0) blocked++;
        end
        bus.load_valid = 1'b0;
        n_checks++; if (blocked !== 0) $display("FAIL fdl_no_valid got=%0d valid cycles exp=0", blocked); else n_pass++;
        n_checks++; if (bus.fetch_instr !== w0) $display("FAIL fdl_hold got=%h exp=%h", bus.fetch_instr, w0); else n_pass++;
        tick();
        bus.fetch_req = 1'b0;
        n_checks++; if ({bus.fetch_valid, bus.fetch_instr} !== {1'b1, w0}) $display("FAIL fdl_retry got v=%b w=%h exp v=1 w=%h", bus.fetch_valid, bus.fetch_instr, w0); else n_pass++;
    endtask

    task automatic test_len_zero();
        logic v, e, me;
        logic [31:0] w, mw;
        bus.load_start = 1'b1;
        bus.load_base  = IDX_W'($urandom_range(DEPTH - 1));
        bus.load_len   = '0;
        tick();
        bus.load_start = 1'b0;
        n_checks++; if ({bus.load_done, bus.load_busy, bus.fetch_rdy} !== 3'b101) $display("FAIL len0_pulse got done/busy/rdy=%b%b%b exp=101", bus.load_done, bus.load_busy, bus.fetch_rdy); else n_pass++;
        tick();
        n_checks++; if (bus.load_done !== 1'b0) $display("FAIL len0_pulse_end got=%b exp=0", bus.load_done); else n_pass++;
        fetch_once(32'h000, v, w, e);
        model_fetch(32'h000, me, mw);
        n_checks++; if ({v, e, w} !== {1'b1, me, mw}) $display("FAIL len0_fetch got e=%b w=%h exp e=%b w=%h", e, w, me, mw); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[$];
        int rb, nvalid;
        logic d1, d2, me;
        logic [31:0] mw;
        for (int i = 0; i < 8; i++) words.push_back($urandom());
        load_image(0, 8, words, 20, rb, d1, d2);
        nvalid = 0;
        bus.fetch_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.fetch_addr = 32'(i * 4);
            tick();
            if (bus.fetch_valid === 1'b1) nvalid++;
            model_fetch(32'(i * 4), me, mw);
            n_checks++; if (bus.fetch_instr !== mw) $display("FAIL b2b_fetch idx=%0d got=%h exp=%h", i, bus.fetch_instr, mw); else n_pass++;
        end
        bus.fetch_req = 1'b0;
        n_checks++; if (nvalid !== 8) $display("FAIL b2b_valid_count got=%0d exp=8", nvalid); else n_pass++;
        tick();
        n_checks++; if (bus.fetch_valid !== 1'b0) $display("FAIL b2b_idle_valid got=%b exp=0", bus.fetch_valid); else n_pass++;
    endtask

    task automatic test_same_cycle();
        logic [31:0] old_w, new_w;
        logic v, e;
        logic [31:0] w;
        old_w = model_mem[4];
        new_w = ~old_w;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h010;
        bus.load_start = 1'b1;
        bus.load_base  = IDX_W'(4);
        bus.load_len   = LEN_W'(1);
        tick();
        bus.fetch_req  = 1'b0;
        bus.load_start = 1'b0;
        n_checks++; if ({bus.fetch_valid, bus.fetch_instr, bus.load_busy} !== {1'b1, old_w, 1'b1}) $display("FAIL same_cycle got v=%b w=%h busy=%b exp v=1 w=%h busy=1", bus.fetch_valid, bus.fetch_instr, bus.load_busy, old_w); else n_pass++;
        bus.load_valid = 1'b1;
        bus.load_data  = new_w;
        tick();
        bus.load_valid = 1'b0;
        model_mem[4] = new_w;
        n_checks++; if (bus.load_done !== 1'b1) $display("FAIL same_cycle_done got=%b exp=1", bus.load_done); else n_pass++;
        fetch_once(32'h010, v, w, e);
        n_checks++; if ({v, e, w} !== {1'b1, 1'b0, new_w}) $display("FAIL same_cycle_new got e=%b w=%h exp e=0 w=%h", e, w, new_w); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            logic [31:0] words[$];
            int base, len, rb;
            logic d1, d2, v, e, me;
            logic [31:0] w, mw, a;
            base = $urandom_range(DEPTH - 1);
            len  = $urandom_range(6);
            for (int i = 0; i < len; i++) words.push_back($urandom());
            load_image(base, len, words, 30, rb, d1, d2);
            n_checks++; if ({rb == 0, d1, d2} !== 3'b110) $display("FAIL rnd_load it=%0d bad=%0d done=%b%b exp bad=0 done=10", it, rb, d1, d2); else n_pass++;
            for (int k = 0; k < 6; k++) begin
                if ($urandom_range(3) != 0) a = 32'($urandom_range(DEPTH - 1)) << 2;
                else                         a = $urandom();
                if (k == 0) a = 32'((base % DEPTH) * 4);
                fetch_once(a, v, w, e);
                model_fetch(a, me, mw);
                n_checks++; if ({v, e, w} !== {1'b1, me, mw}) $display("FAIL rnd_fetch addr=%h got v=%b e=%b w=%h exp v=1 e=%b w=%h", a, v, e, w, me, mw); else n_pass++;
            end
        end
    endtask

    // Hard stop if the run ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_len   = '0;
        bus.load_data  = '0;
        bus.load_valid = 1'b0;
        test_reset();
        test_load_basic();
        test_errors();
        test_wrap();
        test_reset_mid_load();
        test_fetch_during_load();
        test_len_zero();
        test_back_to_back();
        test_same_cycle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
